// File: rtl/fetch_unit_pkg.sv
// Shared types and instruction-field positions for the fetch unit.
// PcSel_t and opcodes_t are the control-path encodings; the rest is fetch-local.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        PcWait = 2'd0,
        PcInc  = 2'd1,
        PcJmp  = 2'd2
    } PcSel_t;

    typedef enum logic [3:0] {
        NOOP   = 4'h0,
        WAIT0  = 4'h1,
        LDI    = 4'h2,
        ADDI   = 4'h3,
        ADD    = 4'h4,
        SUB    = 4'h5,
        AND_OP = 4'h6,
        OR_OP  = 4'h7,
        XOR_OP = 4'h8,
        SHL    = 4'h9,
        SHR    = 4'hA,
        LD     = 4'hB,
        ST     = 4'hC,
        JMP    = 4'hD,
        JZ     = 4'hE,
        HALT   = 4'hF
    } opcodes_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD
    } pc_op_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int REG_MSB = 10;
    localparam int REG_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel: the fetch unit is master, program memory is slave.
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  IAddr;
    logic               IReq;
    logic               IAck;
    logic [INSTR_W-1:0] IData;

    modport master (output IAddr, output IReq, input IAck, input IData);
    modport slave  (input IAddr, input IReq, output IAck, output IData);
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: hold, wrap-around increment or load, reset to RESET_PC.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pc_op_t            pc_op,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        case (pc_op)
            PC_INC:  pc_d = pc_q + 1'b1;
            PC_LOAD: pc_d = load_addr;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns PC and IR, fetches over a req/ack channel, slices IR into fields.
// Optional instruction breakpoint enabled by defining FETCH_BREAKPOINT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              nReset,
    input  PcSel_t            PcSel,
    input  logic [ADDR_W-1:0] JmpAddr,
    fetch_unit_if.master      imem,
    output opcodes_t          OpCode,
    output logic [7:0]        Imm,
    output logic [2:0]        RegAddr,
    output logic              InstrValid,
    output logic [ADDR_W-1:0] Pc
`ifdef FETCH_BREAKPOINT_EN
    ,
    input  logic [ADDR_W-1:0] BpAddr,
    input  logic              BpEnable,
    output logic              BpHit
`endif
);
    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               pending_q, pending_d;
    pc_op_t             pc_op;
    logic [ADDR_W-1:0]  pc;
    logic               ireq;
    logic               instr_valid;
    logic               ir_unused;
`ifdef FETCH_BREAKPOINT_EN
    logic               bp_hit_q, bp_hit_d;
`endif

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (Clock),
        .rst_n     (nReset),
        .pc_op     (pc_op),
        .load_addr (JmpAddr),
        .pc        (pc)
    );

    // pending_q marks the first fetch after reset so IReq stays low while in reset
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pending_d   = pending_q;
        pc_op       = PC_HOLD;
        ireq        = 1'b0;
        instr_valid = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
        bp_hit_d    = bp_hit_q;
`endif
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    state_d   = REQ;
                end
`ifdef FETCH_BREAKPOINT_EN
                else if (bp_hit_q) begin
                    if (!BpEnable) begin
                        bp_hit_d = 1'b0;
                        state_d  = REQ;
                    end
                end
`endif
                else begin
                    instr_valid = 1'b1;
                    case (PcSel)
                        PcInc: begin
                            pc_op   = PC_INC;
                            state_d = REQ;
                        end
                        PcJmp: begin
                            pc_op   = PC_LOAD;
                            state_d = REQ;
                        end
                        default: pc_op = PC_HOLD;
                    endcase
                end
            end
            REQ, WAIT: begin
                ireq = 1'b1;
                if (imem.IAck) begin
                    ir_d    = imem.IData;
                    state_d = IDLE;
`ifdef FETCH_BREAKPOINT_EN
                    if (BpEnable && (pc == BpAddr)) begin
                        bp_hit_d = 1'b1;
                        ir_d     = '0;
                    end
`endif
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            pending_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pending_q <= pending_d;
        end
    end

`ifdef FETCH_BREAKPOINT_EN
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) bp_hit_q <= 1'b0;
        else         bp_hit_q <= bp_hit_d;
    end

    assign BpHit = bp_hit_q;
`endif

    assign imem.IAddr = pc;
    assign imem.IReq  = ireq;
    assign InstrValid = instr_valid;
    assign Pc         = pc;
    assign OpCode     = opcodes_t'(ir_q[OPC_MSB:OPC_LSB]);
    assign RegAddr    = ir_q[REG_MSB:REG_LSB];
    assign Imm        = ir_q[IMM_MSB:IMM_LSB];
    assign ir_unused  = ir_q[11];
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the program counter and instruction register for the three-phase (Fetch/Read/Execute) processor.
- Consumes PcSel and the jump target produced by the control/ALU path.
- Issues instruction-memory reads over a req/ack handshake and presents the decoded OpCode, immediate and register fields to the control and datapath.
- Sits between program memory and the control block.

Parameters:
- ADDR_W, 8, program-counter and instruction-address width.
- INSTR_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- Clock  in  1  system clock, rising-edge.
- nReset  in  1  asynchronous active-low reset.
- PcSel  in  opcodes::PcSel_t  PC update select: PcWait, PcInc, PcJmp.
- JmpAddr  in  ADDR_W  jump target, used when PcSel==PcJmp.
- IAddr  out  ADDR_W  instruction-memory address.
- IReq  out  1  read request to instruction memory.
- IAck  in  1  memory has IData valid this cycle.
- IData  in  INSTR_W  instruction word from memory.
- OpCode  out  opcodes::opcodes_t  = IR[15:12].
- Imm  out  8  = IR[7:0].
- RegAddr  out  3  = IR[10:8].
- InstrValid  out  1  IR holds the instruction at PC.
- Pc  out  ADDR_W  current PC, for debug.

Behaviour:
- Interface: one clock (Clock); reset nReset is asynchronous, active-low.
- Reset values: Pc=RESET_PC, IR=0 (OpCode decodes to NOOP), IReq=0, InstrValid=0. The FSM enters REQ on the first clock after reset release.
- FSM states and transitions:
  - IDLE: InstrValid=1, IReq=0.
  - REQ: IReq=1, IAddr=Pc, InstrValid=0. On IAck=1, IR<=IData and go to IDLE; otherwise go to WAIT.
  - WAIT: IReq=1, IAddr=Pc. Stays until IAck=1, then latches IR and goes to IDLE.
- Latency: with a zero-wait memory (IAck=1 in the REQ cycle), InstrValid rises one cycle after the fetch is launched.
- IReq and IAddr are held stable from assertion until the IAck cycle inclusive. IAck without IReq is ignored.
- PC update is evaluated only in IDLE:
  - PcWait: hold Pc and IR.
  - PcInc: Pc<=Pc+1, modulo 2^ADDR_W (e.g. 8'hFF->8'h00), then go to REQ.
  - PcJmp: Pc<=JmpAddr, then go to REQ.
  - Any other encoding is treated as PcWait.
- PcSel is ignored in REQ/WAIT. While InstrValid=0, downstream must not act on OpCode.
- OpCode, Imm and RegAddr are combinational slices of IR and are stable while InstrValid=1.
- Reset asserted mid-fetch aborts the request asynchronously: IReq=0 immediately and Pc=RESET_PC. A late IAck after reset release is ignored because the FSM is not in WAIT.

Optional Feature:
- Macro: FETCH_BREAKPOINT_EN.
- Defined:
  - Adds inputs BpAddr (ADDR_W) and BpEnable (1), and output BpHit (1).
  - When an instruction fetch completes with Pc==BpAddr and BpEnable=1, BpHit is set (sticky) and IR is forced to WAIT0-as-NOOP hold: InstrValid stays 0 until BpEnable is deasserted, then the fetch is reissued.
  - BpHit clears on reset or on BpEnable falling.
- Undefined: ports absent; behaviour exactly as above.

Decomposition:
- opcodes package:
  - Existing PcSel_t and opcodes_t.
  - Add fetch_state_t {IDLE, REQ, WAIT}.
  - Add localparams for the instruction field positions: OPC_MSB=15, OPC_LSB=12, REG_MSB=10, REG_LSB=8, IMM_MSB=7, IMM_LSB=0.
- One natural sub-module: pc_reg, the ADDR_W-bit PC register with hold/increment/load and reset to RESET_PC, instantiated once.

Test Plan:
- Reset release, memory acks in the REQ cycle with IData=16'h3A05 → IAddr=0, InstrValid=1 on the next cycle, OpCode=4'h3, RegAddr=3'd2, Imm=8'h05.
- Memory with 3 wait cycles → IReq and IAddr stable for 4 cycles, IR unchanged until the IAck cycle, InstrValid low throughout.
- Pc=8'hFF, PcSel=PcInc in IDLE → Pc=8'h00, fetch issued at IAddr=0.
- PcSel=PcJmp with JmpAddr=8'h40 → next IAddr=8'h40. Asserting PcSel=PcInc during WAIT → no PC change.
- nReset pulsed low during WAIT → IReq=0 at once, Pc=0. An IAck the cycle after release is ignored.
- With FETCH_BREAKPOINT_EN, BpAddr=8'h02, BpEnable=1, incrementing from 0 → BpHit=1 after the fetch at address 2, InstrValid held 0. Dropping BpEnable → refetch at address 2 and BpHit=0.
